// File: rtl/subbytes_dma.sv
// AES SubBytes DMA: reads each source word, replaces every byte through the
// memory-resident S-box and writes the result out. Optional macro: SUBBYTES_ADDKEY_EN.
module subbytes_dma #(
  parameter logic [31:0] SBOX_BASE = 32'h0000_0200,
  parameter int          NUM_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
`ifdef SUBBYTES_ADDKEY_EN
  input  logic [31:0] key_addr,
`endif
  output logic        busy,
  output logic        done,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  // start is a one-cycle request honoured only while idle (busy=0); done pulses
  // for exactly one cycle after the last destination write has been issued.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LK   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
`ifdef SUBBYTES_ADDKEY_EN
    , S_KEY = 3'd5
`endif
  } state_t;

  localparam logic [5:0]  LAST_CNT     = 6'(NUM_WORDS - 1);
  localparam logic [31:0] SBOX_ALIGNED = {SBOX_BASE[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] res_q, res_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
`ifdef SUBBYTES_ADDKEY_EN
  logic [31:0] key_q, key_d;
`endif

  logic [31:0] word_off;
  logic [7:0]  lk_byte;

  assign word_off  = {24'b0, cnt_q, 2'b00};
  assign lk_byte   = word_q[{idx_q, 3'b000} +: 8];
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      res_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
`ifdef SUBBYTES_ADDKEY_EN
      key_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      res_q   <= res_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
`ifdef SUBBYTES_ADDKEY_EN
      key_q   <= key_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    word_d    = word_q;
    res_d     = res_q;
    src_d     = src_q;
    dst_d     = dst_q;
`ifdef SUBBYTES_ADDKEY_EN
    key_d     = key_q;
`endif
    busy      = 1'b1;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          src_d   = {src_addr[31:2], 2'b00};
          dst_d   = {dst_addr[31:2], 2'b00};
`ifdef SUBBYTES_ADDKEY_EN
          key_d   = {key_addr[31:2], 2'b00};
`endif
          cnt_d   = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        mem_re   = 1'b1;
        mem_addr = src_q + word_off;
        word_d   = mem_rdata;
        idx_d    = 2'd3;
`ifdef SUBBYTES_ADDKEY_EN
        state_d  = S_KEY;
`else
        state_d  = S_LK;
`endif
      end
`ifdef SUBBYTES_ADDKEY_EN
      S_KEY: begin
        mem_re   = 1'b1;
        mem_addr = key_q + word_off;
        word_d   = word_q ^ mem_rdata;
        state_d  = S_LK;
      end
`endif
      // One table lookup per byte, most significant byte first.
      S_LK: begin
        mem_re   = 1'b1;
        mem_addr = SBOX_ALIGNED + {22'b0, lk_byte, 2'b00};
        res_d[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
        idx_d    = idx_q - 2'd1;
        if (idx_q == 2'd0) state_d = S_WR;
      end
      S_WR: begin
        mem_we    = 1'b1;
        mem_addr  = dst_q + word_off;
        mem_wdata = res_q;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 6'd1;
          state_d = S_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_subbytes_dma.sv
// Bench for subbytes_dma: behavioural data memory, scoreboard of expected reads
// and writes built from an S-box derived from the GF(2^8) inverse and affine map.
module tb_subbytes_dma;
  localparam int NW = 4;
`ifdef SUBBYTES_ADDKEY_EN
  localparam int WC = 7;
`else
  localparam int WC = 6;
`endif
  localparam int          LAT      = WC * NW + 1;
  localparam logic [31:0] SBOX     = 32'h0000_0200;
  localparam logic [31:0] KEY_BASE = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
`ifdef SUBBYTES_ADDKEY_EN
  logic [31:0] key_addr;
`endif
  logic        busy;
  logic        done;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  state_dbg;

  logic [31:0] mem [1024];
  logic [7:0]  sbox [256];

  logic [63:0] exp_q[$];
  logic [31:0] exp_rd_q[$];
  int vectors = 0;
  int miscompares = 0;

  subbytes_dma #(.SBOX_BASE(SBOX), .NUM_WORDS(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
`ifdef SUBBYTES_ADDKEY_EN
    .key_addr  (key_addr),
`endif
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // memory model: combinational read, write on posedge
  assign mem_rdata = (mem_re === 1'b1) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr[11:2]] = mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe the DUT issues is matched against the queues
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("we_re_exclusive", 64'(mem_re), 64'd0);
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("wr_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
    end else if (mem_re === 1'b1) begin
      check("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
      if (exp_rd_q.size() != 0) check("rd_addr", 64'(mem_addr), 64'(exp_rd_q.pop_front()));
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse plus the affine transform
  task automatic build_sbox();
    logic [7:0] x, inv, s;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[v] = s;
    end
  endtask

  task automatic push_expect(input logic [31:0] src, input logic [31:0] dst);
    logic [31:0] s, d, a, x, y;
    logic [7:0]  b;
`ifdef SUBBYTES_ADDKEY_EN
    logic [31:0] k;
`endif
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    y = '0;
    for (int w = 0; w < NW; w++) begin
      a = s + 32'(4 * w);
      exp_rd_q.push_back(a);
      x = mem[a[11:2]];
`ifdef SUBBYTES_ADDKEY_EN
      k = KEY_BASE + 32'(4 * w);
      exp_rd_q.push_back(k);
      x = x ^ mem[k[11:2]];
`endif
      for (int i = 3; i >= 0; i--) begin
        b = x[8 * i +: 8];
        exp_rd_q.push_back(SBOX + {22'b0, b, 2'b00});
        y[8 * i +: 8] = sbox[b];
      end
      exp_q.push_back({d + 32'(4 * w), y});
    end
  endtask

  // driver: one start, optional start pokes at cycles 3 and 10 while busy
  task automatic run_block(input logic [31:0] src, input logic [31:0] dst, input bit poke);
    int n, done_at, done_cnt, busy_cnt;
    push_expect(src, dst);
    @(negedge clk);
    start = 1'b1; src_addr = src; dst_addr = dst;
    @(negedge clk);
    start = 1'b0;
    n = 1; done_at = 0; done_cnt = 0; busy_cnt = 0;
    while (busy === 1'b1 && n <= 200) begin
      busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = n;
      end
      if (poke) begin
        start    = (n == 3 || n == 10);
        src_addr = 32'h0000_0600;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("no_timeout", 64'(n <= 200), 64'd1);
    check("done_cycle", 64'(done_at), 64'(LAT));
    check("busy_cycles", 64'(busy_cnt), 64'(LAT));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("writes_left", 64'(exp_q.size()), 64'd0);
    check("reads_left", 64'(exp_rd_q.size()), 64'd0);
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    check({tag, "_re"}, 64'(mem_re), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0;
`ifdef SUBBYTES_ADDKEY_EN
    key_addr = KEY_BASE;
`endif
    build_sbox();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h2b7e1516; mem[1] = 32'h28aed2a6; mem[2] = 32'habf71588; mem[3] = 32'h09cf4f3c;
    mem[4] = 32'h3243f6a8; mem[5] = 32'h885a308d; mem[6] = 32'h313198a2; mem[7] = 32'he0370734;
    for (int i = 0; i < 256; i++) mem[32'h80 + i] = {24'b0, sbox[i]};
    mem[10'h3fe] = $urandom; mem[10'h3ff] = $urandom;

    // reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_done", 64'(done), 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;

    // known AES vectors
    run_block(32'h10, 32'h100, 1'b0);
`ifdef SUBBYTES_ADDKEY_EN
    check("aes_word0", 64'(mem[10'h40]), 64'h d42711ae);
    check("aes_word1", 64'(mem[10'h41]), 64'h e0bf98f1);
`else
    check("aes_word0", 64'(mem[10'h40]), 64'h231a42c2);
    check("aes_word1", 64'(mem[10'h41]), 64'hc4be045d);
`endif

    // misaligned addresses are rounded down
    run_block(32'h13, 32'h182, 1'b0);

    // in-place, then again for S(S(x))
    run_block(32'h10, 32'h10, 1'b0);
`ifndef SUBBYTES_ADDKEY_EN
    check("inplace_once", 64'(mem[4]), 64'h231a42c2);
`endif
    run_block(32'h10, 32'h10, 1'b0);
`ifndef SUBBYTES_ADDKEY_EN
    check("inplace_twice", 64'(mem[4]), 64'h26a22c25);
`endif

    // random data blocks
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NW; i++) mem[32'h180 + i] = $urandom;
      run_block(32'h600 | 32'($urandom_range(0, 3)), 32'h700 + 32'(r * 16), 1'b0);
    end

    // start while busy is ignored
    run_block(32'h600, 32'h780, 1'b1);

    // reset aborts mid-run (cycle 12 is the second write)
    push_expect(32'h10, 32'h140);
    @(negedge clk);
    start = 1'b1; src_addr = 32'h10; dst_addr = 32'h140;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("abort");
    reset = 1'b0;
    exp_q.delete();
    exp_rd_q.delete();
    repeat (4) @(negedge clk);
    check_idle("abort_quiet");

    // start and reset together: reset wins
    start = 1'b1; reset = 1'b1; src_addr = 32'h10; dst_addr = 32'h140;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check_idle("start_reset");
    repeat (2) @(negedge clk);
    check_idle("start_reset_quiet");

    run_block(32'h10, 32'h140, 1'b0);

    // modulo-2^32 address wrap on source, then on destination
    run_block(32'hffff_fff8, 32'h800, 1'b0);
    run_block(32'h10, 32'hffff_fff8, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/subbytes_dma.md
Name: subbytes_dma

Overview:
- Memory-side initiator for the data memory.
- Drives the memory's we/re/addr/wdata and samples rdata to run AES SubBytes over a block of words.
- Each word is read from a source address, and each of its 4 bytes is replaced by the S-box table entry held in memory at SBOX_BASE.
- The substituted word is written to a destination address. The block sits between the CPU's control registers and the data memory port, and replaces the software S-box loop.

Parameters:
- SBOX_BASE, 32'h0000_0200: byte address of S-box entry 0. Each entry is one word; the value is in bits [7:0].
- NUM_WORDS, 4: words processed per start. Legal range 1..64.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  source byte address; latched on accepted start; bits [1:0] ignored.
- dst_addr  in  32  destination byte address; latched on accepted start; bits [1:0] ignored.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the block completes.
- mem_we  out  1  memory write strobe; the memory writes on the posedge.
- mem_re  out  1  memory read enable; the memory returns 0 when this is low.
- mem_addr  out  32  memory byte address; bits [1:0] always 2'b00.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; combinational, valid in the same cycle as mem_re/mem_addr.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, mem_we, mem_re are 0; mem_addr and mem_wdata are 0.
  - The word counter, byte index and data registers are cleared.
- IDLE:
  - All memory strobes are 0.
  - start=1 latches src/dst (aligned to {addr[31:2],2'b00}) and clears the word counter, then moves to RD.
- RD (1 cycle):
  - mem_re=1, mem_addr = src + 4*cnt.
  - mem_rdata is registered into word_reg; byte index i is set to 3; move to LK.
- LK (4 cycles, i = 3,2,1,0, MSB byte first):
  - mem_re=1, mem_addr = SBOX_BASE + {24'b0, word_reg[8i+7:8i], 2'b00}.
  - mem_rdata[7:0] is registered into res_reg[8i+7:8i]; upper rdata bits are ignored.
  - After i=0, move to WR.
- WR (1 cycle):
  - mem_we=1, mem_re=0, mem_addr = dst + 4*cnt, mem_wdata = res_reg.
  - If cnt == NUM_WORDS-1, move to DONE; otherwise cnt++ and move to RD.
- DONE (1 cycle): done=1, busy=1; then IDLE.
- mem_we and mem_re are never both 1.
- Strobes and addresses are registered-state decodes. Outputs are glitch-free relative to state, and rdata is sampled in the same cycle.
- Latency:
  - Start is accepted at edge k.
  - Each word takes 6 cycles (RD + 4×LK + WR).
  - done is high in cycle k + 6*NUM_WORDS + 1, i.e. cycle 25 for NUM_WORDS=4.
- Boundaries:
  - start while busy is ignored; it is neither queued nor restarted.
  - src == dst (in-place) is legal, because each word is read before it is written.
  - Address arithmetic wraps modulo 2^32 with no error.
  - The counter width is 6 bits. cnt never exceeds NUM_WORDS-1.
  - reset during any state aborts on that edge. No further strobes are issued. A write already issued in WR is not undone; partial destination contents are undefined.
  - start and reset high together: reset wins.

Optional Feature:
- Macro SUBBYTES_ADDKEY_EN.
- When defined:
  - Adds input key_addr (32 bits), latched on start.
  - Adds state KEY (1 cycle) between RD and LK: mem_re=1, mem_addr = key + 4*cnt, and word_reg <= word_reg ^ mem_rdata.
  - This gives AddRoundKey followed by SubBytes; per-word cost is 7 cycles and done falls at k + 7*NUM_WORDS + 1.
- When undefined: no key_addr port and no KEY state; behaviour is exactly as above.

Test Plan:
- Memory loaded from its reset image; start with src=0x10, dst=0x100, NUM_WORDS=1 -> mem word 0x100 = 0x231a42c2; done in cycle 7; exactly 4 S-box reads at 0x2C8, 0x30C, 0x5D8, 0x4A0.
- NUM_WORDS=4, src=0x10, dst=0x100 -> word 0x104 = 0xc4be045d; done at cycle 25; busy high for 25 cycles; 4 write strobes at 0x100, 0x104, 0x108, 0x10C only.
- In-place: src=dst=0x10, NUM_WORDS=1 -> word 0x10 = 0x231a42c2; a rerun gives S(S(x)) = 0x26a22c25.
- start pulsed at cycles 3 and 10 during a run -> ignored; only one done pulse; then reset asserted at cycle 12 of a new run -> next cycle busy=0, mem_we=0, mem_re=0, state IDLE; a following start completes normally.
- With SUBBYTES_ADDKEY_EN: src=0x10, key_addr=0x0, dst=0x100 -> word 0x100 = 0xd42711ae (0x3243f6a8 ^ 0x2b7e1516 = 0x193de3be, then SubBytes); done in cycle 8.
